p1_win_overlay: RTL and testbench
=================================

# p1_win_overlay

Scan-out stage that consumes the 1536 x 16 "player 1 wins" bitmap memory and turns it into overlay pixels for the VGA path. Each VGA coordinate is mapped into a 192 x 128 one-bit-per-pixel banner, placed at a programmable origin with 1x/2x/4x scaling. The stage drives the memory's address, chip-select and clock-enable, and emits a hit flag plus foreground colour at a fixed two-clock latency. Frame-synchronous shadow registers and a blink timer prevent tearing and let the banner flash.

## Interface
Parameters:
- `IMG_W`, 192: banner width in source pixels (12 words per row).
- `IMG_H`, 128: banner height in source rows.
- `WORDS_PER_ROW`, 12: 16-bit words per source row.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: current `hcount`/`vcount` is a real pixel.
- `hcount` in 11: pixel column, 0..639.
- `vcount` in 10: pixel row, 0..479.
- `vsync_start` in 1: one-cycle pulse at frame start; shadow-latch point.
- `cfg_enable` in 1: show banner.
- `cfg_x0` in 10: left edge, in screen pixels.
- `cfg_y0` in 10: top edge, in screen pixels.
- `cfg_scale` in 2: 0 = 1x, 1 = 2x, 2 = 4x, 3 = treated as 4x.
- `cfg_blink` in 6: frames per blink half-period; 0 = steady.
- `cfg_fg_rgb` in 24: foreground colour.
- `rom_address` out 11: word address to bitmap memory.
- `rom_chipselect` out 1: memory access strobe.
- `rom_clken` out 1: memory clock enable; equals `rom_chipselect`.
- `rom_readdata` in 16: memory data. Valid the cycle after the address is applied (registered address, unregistered output).
- `out_valid` in→out 1: `in_valid` delayed 2 clocks.
- `out_hit` out 1: banner pixel is set and visible.
- `out_rgb` out 24: `cfg_fg_rgb` (shadow copy) when hit, else 0.

## Operation
- **Shadow registers.** On `vsync_start`, latch `enable`, `x0`, `y0`, `scale`, `fg_rgb` and `blink` into shadows. All geometry and colour use the shadows only; `cfg_*` changes mid-frame have no effect until the next pulse.
- **Blink FSM.** States OFF, SHOW, HIDE, all advancing only on `vsync_start`.
  - OFF → SHOW when the latched enable is 1; the frame counter clears.
  - SHOW/HIDE → OFF when the latched enable is 0.
  - With blink = 0: stay in SHOW.
  - Otherwise the counter increments each frame. When counter = blink − 1, it wraps to 0 and the state toggles SHOW ↔ HIDE.
  - `visible` = (state == SHOW).
- **Geometry (stage 0, combinational).**
  - rel_x = hcount − x0 and rel_y = vcount − y0, computed 12-bit signed.
  - in_box = rel_x ≥ 0, rel_x < 192 << scale, rel_y ≥ 0, rel_y < 128 << scale.
  - sx = rel_x >> scale; sy = rel_y >> scale.
  - Address = sy·12 + sx[7:4], computed as (sy << 3) + (sy << 2) + sx[7:4]. Maximum value 1535; never exceeds 1535.
- **Memory strobes.** `rom_chipselect` = `rom_clken` = in_valid & in_box & visible. `rom_address` = 0 when the strobe is low.
- **Stage 1 register.** Captures valid, strobe, and bit index = 15 − sx[3:0]. The MSB of each word is the leftmost pixel.
- **Stage 2 register.**
  - `out_valid` = stage-1 valid.
  - `out_hit` = stage-1 strobe & `rom_readdata[bit]`.
  - `out_rgb` = hit ? fg : 0.

## Timing
- **Latency.** Coordinate presented in cycle N → outputs in cycle N+2, including gaps in `in_valid`. No back-pressure exists.
- **Reset values.**
  - Outputs: `out_valid`, `out_hit`, `out_rgb`, `rom_address`, `rom_chipselect`, `rom_clken` all 0.
  - Internal: FSM in OFF, counter 0, all shadows 0.
  - Reset asserted mid-frame: pipeline contents are discarded immediately. The banner stays hidden until the first `vsync_start` after reset with `cfg_enable` = 1.
- **Same-cycle `vsync_start` and `in_valid`.** Pixels in that cycle use the pre-latch shadows. The new shadows apply from the next cycle.
- **Edges.**
  - Right edge: the pixel at x0 + (192 << scale) − 1 is in the box; the next pixel is not.
  - Off-screen placement (x0 ≥ 640 − width): clip silently, no wrap.
  - rel_x < 0 is never treated as in the box.
- **Blink changes.** A change of `cfg_blink` while blinking takes effect at the next latch. If counter ≥ new blink − 1, the counter wraps and the state toggles at that frame.

## Test plan
- **Reset/idle.** Reset, then a full frame with `cfg_enable` = 0 → `out_hit` = 0 and `rom_chipselect` = 0 throughout; `out_valid` tracks `in_valid` delayed 2.
- **1x placement.** x0 = 100, y0 = 50, scale = 0; bitmap word 0 = 0x8001, word 13 = 0x4000.
  - (100,50) → address 0; hit 2 cycles later with `out_rgb` = fg.
  - (101,50) → miss; (115,50) → hit.
  - (117,51) → address 13, bit 14, hit.
  - (99,50) and (292,50) → no strobe.
- **2x scale.** x0 = 0, y0 = 0, scale = 1: screen (2,2) and (3,3) → address 0, bit 14. Screen (383,255) → address 1535, bit 0. Screen (384,0) → out of box.
- **Shadowing.** Change x0 from 100 to 200 mid-frame → current-frame hits unchanged; next frame (200,50) → address 0.
- **Blink.** blink = 2 → visible 2 frames, hidden 2 frames, repeating. `cfg_enable` → 0 → no hits from the next frame on.
- **Reset mid-line.** Assert reset during an active banner row → outputs go to 0 asynchronously; no hits appear after release until the next enabled `vsync_start`.

Source files
------------

// File: rtl/p1_win_overlay.sv
// Overlay scan-out for the 192x128 1bpp "player 1 wins" banner: maps VGA coordinates
// to bitmap words, drives the memory strobes and returns hit/colour two clocks later.
`timescale 1ns/1ps
module p1_win_overlay #(
  parameter int IMG_W         = 192,
  parameter int IMG_H         = 128,
  parameter int WORDS_PER_ROW = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        vsync_start,
  input  logic        cfg_enable,
  input  logic [9:0]  cfg_x0,
  input  logic [9:0]  cfg_y0,
  input  logic [1:0]  cfg_scale,
  input  logic [5:0]  cfg_blink,
  input  logic [23:0] cfg_fg_rgb,
  output logic [10:0] rom_address,
  output logic        rom_chipselect,
  output logic        rom_clken,
  input  logic [15:0] rom_readdata,
  output logic        out_valid,
  output logic        out_hit,
  output logic [23:0] out_rgb,
  output logic [1:0]  blink_state
);

  // Handshake: in_valid qualifies hcount/vcount each cycle; out_valid is in_valid
  // delayed by exactly two clocks. There is no back-pressure.

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SHOW = 2'd1,
    ST_HIDE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [5:0]  frame_cnt, frame_cnt_n;

  logic        sh_enable;
  logic [9:0]  sh_x0, sh_y0;
  logic [1:0]  sh_scale;
  logic [23:0] sh_fg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_enable <= 1'b0;
      sh_x0     <= '0;
      sh_y0     <= '0;
      sh_scale  <= '0;
      sh_fg     <= '0;
      state     <= ST_OFF;
      frame_cnt <= '0;
    end else begin
      if (vsync_start) begin
        sh_enable <= cfg_enable;
        sh_x0     <= cfg_x0;
        sh_y0     <= cfg_y0;
        sh_scale  <= cfg_scale;
        sh_fg     <= cfg_fg_rgb;
      end
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
    end
  end

  // The blink period is sampled at the frame latch, so a new value acts immediately.
  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    if (vsync_start) begin
      case (state)
        ST_OFF: begin
          if (cfg_enable) begin
            state_n     = ST_SHOW;
            frame_cnt_n = '0;
          end
        end
        default: begin
          if (!cfg_enable) begin
            state_n     = ST_OFF;
            frame_cnt_n = '0;
          end else if (cfg_blink == 6'd0) begin
            state_n     = ST_SHOW;
            frame_cnt_n = '0;
          end else if (frame_cnt >= cfg_blink - 6'd1) begin
            state_n     = (state == ST_SHOW) ? ST_HIDE : ST_SHOW;
            frame_cnt_n = '0;
          end else begin
            frame_cnt_n = frame_cnt + 6'd1;
          end
        end
      endcase
    end
  end

  assign blink_state = state;

  logic        visible;
  logic [1:0]  scale_eff;
  logic [11:0] rel_x, rel_y, box_w, box_h;
  logic        in_box, strobe;
  logic [7:0]  sx;
  logic [6:0]  sy;
  logic [10:0] word_addr;

  assign visible   = (state == ST_SHOW) && sh_enable;
  assign scale_eff = (sh_scale == 2'd3) ? 2'd2 : sh_scale;
  assign rel_x     = {1'b0, hcount} - {2'b0, sh_x0};
  assign rel_y     = {2'b0, vcount} - {2'b0, sh_y0};
  assign box_w     = 12'(IMG_W) << scale_eff;
  assign box_h     = 12'(IMG_H) << scale_eff;
  assign in_box    = !rel_x[11] && (rel_x < box_w) && !rel_y[11] && (rel_y < box_h);
  assign sx        = 8'(rel_x >> scale_eff);
  assign sy        = 7'(rel_y >> scale_eff);
  // Constant multiply by 12 reduces to (sy << 3) + (sy << 2); max 127*12+11 = 1535.
  assign word_addr = 11'(sy) * 11'(WORDS_PER_ROW) + 11'(sx[7:4]);

  assign strobe         = in_valid && in_box && visible;
  assign rom_chipselect = strobe;
  assign rom_clken      = strobe;
  assign rom_address    = strobe ? word_addr : '0;

  logic       s1_valid, s1_strobe, s1_hit;
  logic [3:0] s1_bit;

  // Word MSB is the leftmost pixel of each 16-pixel group.
  assign s1_hit = s1_strobe && rom_readdata[s1_bit];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_strobe <= 1'b0;
      s1_bit    <= '0;
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_rgb   <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_strobe <= strobe;
      s1_bit    <= 4'd15 - sx[3:0];
      out_valid <= s1_valid;
      out_hit   <= s1_hit;
      out_rgb   <= s1_hit ? sh_fg : '0;
    end
  end

endmodule

// File: tb/tb_p1_win_overlay.sv
// Directed bench for p1_win_overlay: a behavioural geometry model pushes expected
// outputs per cycle; a bitmap memory model answers the DUT's reads.
`timescale 1ns/1ps
module tb_p1_win_overlay;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        vsync_start = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [9:0]  cfg_x0 = '0;
  logic [9:0]  cfg_y0 = '0;
  logic [1:0]  cfg_scale = '0;
  logic [5:0]  cfg_blink = '0;
  logic [23:0] cfg_fg_rgb = '0;
  logic [10:0] rom_address;
  logic        rom_chipselect, rom_clken;
  logic [15:0] rom_readdata;
  logic        out_valid, out_hit;
  logic [23:0] out_rgb;
  logic [1:0]  blink_state;

  p1_win_overlay dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .hcount(hcount), .vcount(vcount),
    .vsync_start(vsync_start), .cfg_enable(cfg_enable), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0),
    .cfg_scale(cfg_scale), .cfg_blink(cfg_blink), .cfg_fg_rgb(cfg_fg_rgb),
    .rom_address(rom_address), .rom_chipselect(rom_chipselect), .rom_clken(rom_clken),
    .rom_readdata(rom_readdata), .out_valid(out_valid), .out_hit(out_hit),
    .out_rgb(out_rgb), .blink_state(blink_state)
  );

  always #5 clk = ~clk;

  // Bitmap memory: registered address, unregistered data.
  logic [15:0] mem [0:1535];
  logic [10:0] rom_q = '0;
  always @(posedge clk) if (rom_clken) rom_q <= rom_address;
  assign rom_readdata = mem[rom_q];

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_q[$];

  // Model of the latched configuration and of banner visibility.
  int          m_x0 = 0, m_y0 = 0, m_scale = 0;
  logic [23:0] m_fg = '0;
  logic        m_vis = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic prime();
    exp_q.delete();
    exp_q.push_back(26'h0);
    exp_q.push_back(26'h0);
  endtask

  // Called at posedge+1; drives one cycle, checks strobes, retires the entry from two cycles ago.
  task automatic tick(input logic v, input int h, input int y, input logic vs);
    int mult, rx, ry, sx, sy, idx, bitn;
    logic cs, hit;
    logic [10:0] ad;
    logic [25:0] e;
    in_valid = v; hcount = 11'(h); vcount = 10'(y); vsync_start = vs;
    mult = 1 << ((m_scale == 3) ? 2 : m_scale);
    rx = h - m_x0;
    ry = y - m_y0;
    cs = v && m_vis && rx >= 0 && ry >= 0 && rx < 192 * mult && ry < 128 * mult;
    ad = '0;
    hit = 1'b0;
    if (cs) begin
      sx = rx / mult;
      sy = ry / mult;
      idx = sy * 12 + sx / 16;
      bitn = 15 - (sx % 16);
      ad = 11'(idx);
      hit = mem[idx][bitn];
    end
    exp_q.push_back({v, hit, hit ? m_fg : 24'h0});
    if (vs) begin
      m_x0 = int'(cfg_x0); m_y0 = int'(cfg_y0); m_scale = int'(cfg_scale); m_fg = cfg_fg_rgb;
    end
    @(negedge clk);
    chk("rom_chipselect", 32'(rom_chipselect), 32'(cs));
    chk("rom_clken", 32'(rom_clken), 32'(cs));
    chk("rom_address", 32'(rom_address), 32'(ad));
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("out_valid", 32'(out_valid), 32'(e[25]));
      chk("out_hit", 32'(out_hit), 32'(e[24]));
      chk("out_rgb", 32'(out_rgb), 32'(e[23:0]));
    end
    @(posedge clk); #1;
    vsync_start = 1'b0;
  endtask

  task automatic vs_tick();
    tick(1'b0, 0, 0, 1'b1);
  endtask

  task automatic probes();
    tick(1'b1, 100, 50, 1'b0);
    tick(1'b1, 115, 50, 1'b0);
    tick(1'b1, 117, 51, 1'b0);
  endtask

  initial begin
    int pat[5];
    pat = '{1, 0, 0, 1, 1};
    for (int i = 0; i < 1536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h8001;
    mem[12] = 16'h4000;
    mem[13] = 16'h4000;
    mem[1535] = 16'h0001;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_hit", 32'(out_hit), 32'd0);
    chk("rst_out_rgb", 32'(out_rgb), 32'd0);
    chk("rst_rom_cs", 32'(rom_chipselect), 32'd0);
    chk("rst_rom_addr", 32'(rom_address), 32'd0);
    chk("rst_state", 32'(blink_state), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    prime();

    // Idle frame: banner disabled, no strobes or hits whatever the coordinates.
    cfg_x0 = 10'd100; cfg_y0 = 10'd50; cfg_fg_rgb = 24'hFFC020;
    vs_tick();
    m_vis = 1'b0;
    for (int i = 0; i < 40; i++)
      tick(1'($urandom_range(0, 1)), $urandom_range(90, 300), $urandom_range(45, 60), 1'b0);

    // 1x placement at (100,50)
    cfg_enable = 1'b1;
    vs_tick();
    m_vis = 1'b1;
    tick(1'b1, 100, 50, 1'b0);
    tick(1'b1, 101, 50, 1'b0);
    tick(1'b1, 115, 50, 1'b0);
    tick(1'b0, 115, 50, 1'b0);
    tick(1'b1, 117, 51, 1'b0);
    tick(1'b1, 99, 50, 1'b0);
    tick(1'b1, 291, 50, 1'b0);
    tick(1'b1, 292, 50, 1'b0);
    tick(1'b1, 100, 177, 1'b0);
    tick(1'b1, 100, 178, 1'b0);
    for (int i = 0; i < 40; i++)
      tick(1'($urandom_range(0, 1)), $urandom_range(95, 300), $urandom_range(45, 185), 1'b0);

    // 2x scale at origin
    cfg_x0 = 10'd0; cfg_y0 = 10'd0; cfg_scale = 2'd1;
    vs_tick();
    tick(1'b1, 2, 2, 1'b0);
    tick(1'b1, 3, 3, 1'b0);
    tick(1'b1, 383, 255, 1'b0);
    tick(1'b1, 384, 0, 1'b0);
    tick(1'b1, 0, 256, 1'b0);

    // Scale code 3 behaves as 4x
    cfg_scale = 2'd3;
    vs_tick();
    tick(1'b1, 767, 0, 1'b0);
    tick(1'b1, 768, 0, 1'b0);
    tick(1'b1, 3, 4, 1'b0);
    tick(1'b1, 767, 511, 1'b0);

    // Shadowing: a mid-frame x0 change waits for the next latch
    cfg_x0 = 10'd100; cfg_y0 = 10'd50; cfg_scale = 2'd0;
    vs_tick();
    tick(1'b1, 100, 50, 1'b0);
    cfg_x0 = 10'd200;
    tick(1'b1, 100, 50, 1'b0);
    tick(1'b1, 200, 50, 1'b0);
    tick(1'b1, 100, 50, 1'b1);
    tick(1'b1, 200, 50, 1'b0);
    tick(1'b1, 100, 50, 1'b0);

    // Blink with period 2, starting from OFF
    cfg_enable = 1'b0;
    vs_tick();
    m_vis = 1'b0;
    probes();
    cfg_enable = 1'b1; cfg_blink = 6'd2; cfg_x0 = 10'd100;
    vs_tick();
    m_vis = 1'b1;
    probes();
    chk("blink_show", 32'(blink_state), 32'd1);
    for (int f = 0; f < 5; f++) begin
      vs_tick();
      m_vis = pat[f][0];
      probes();
    end

    // Disable: no hits from the next frame on
    cfg_enable = 1'b0;
    vs_tick();
    m_vis = 1'b0;
    probes();
    chk("disabled_state", 32'(blink_state), 32'd0);

    // Reset during an active banner row
    cfg_enable = 1'b1; cfg_blink = 6'd0;
    vs_tick();
    m_vis = 1'b1;
    tick(1'b1, 100, 50, 1'b0);
    tick(1'b1, 115, 50, 1'b0);
    in_valid = 1'b1; hcount = 11'd100; vcount = 10'd50;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_hit", 32'(out_hit), 32'd0);
    chk("mid_rst_out_rgb", 32'(out_rgb), 32'd0);
    chk("mid_rst_rom_cs", 32'(rom_chipselect), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    prime();
    m_x0 = 0; m_y0 = 0; m_scale = 0; m_fg = '0; m_vis = 1'b0;
    tick(1'b1, 100, 50, 1'b0);
    tick(1'b1, 115, 50, 1'b0);
    tick(1'b1, 0, 0, 1'b0);
    tick(1'b1, 5, 3, 1'b0);
    vs_tick();
    m_vis = 1'b1;
    tick(1'b1, 100, 50, 1'b0);
    tick(1'b1, 117, 51, 1'b0);
    tick(1'b0, 0, 0, 1'b0);
    tick(1'b0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
